// File: rtl/reg_file.sv
// MAK-8 general-purpose register file with ALU status flags.
// Two bypassed async read ports feed the ALU, one sync write port, one raw debug read port.
module reg_file #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flag_we,
  input  logic              flag_z_in,
  input  logic              flag_c_in,
  input  logic              flag_n_in,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_n,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Only matters when NUM_REGS is not a power of two: such addresses hold no register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
    return 32'(addr) < NUM_REGS;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && addr_ok(wr_addr)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_n <= 1'b0;
    end else if (flag_we) begin
      flag_z <= flag_z_in;
      flag_c <= flag_c_in;
      flag_n <= flag_n_in;
    end
  end

  // Write-first bypass so the ALU sees a result written back in the same cycle.
  always_comb begin
    rd_data_a = '0;
    if (addr_ok(rd_addr_a)) begin
      if (wr_en && (wr_addr == rd_addr_a)) begin
        rd_data_a = wr_data;
      end else begin
        rd_data_a = regs[rd_addr_a];
      end
    end
  end

  always_comb begin
    rd_data_b = '0;
    if (addr_ok(rd_addr_b)) begin
      if (wr_en && (wr_addr == rd_addr_b)) begin
        rd_data_b = wr_data;
      end else begin
        rd_data_b = regs[rd_addr_b];
      end
    end
  end

  // Debug port shows committed state only, never the in-flight write.
  always_comb begin
    dbg_data = '0;
    if (addr_ok(dbg_addr)) begin
      dbg_data = regs[dbg_addr];
    end
  end

endmodule
